dac_frame_buffer: RTL and testbench

Upstream feeder for the four-channel DAC serializer. It accepts 32-bit DAC samples one word at a time, in channel order 0..3, over a valid/ready stream from the host/sample-generation side. It assembles complete 4-channel frames into a frame FIFO. On each single-cycle dac_request pulse from the serializer it presents the next frame on the flattened dac_buffer bus. It provides prefill gating, zero-output underrun handling, and stream-framing error detection.

---
 rtl/dac_frame_buffer.sv | 72 +++++++
 tb/tb_dac_frame_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_buffer.sv
// dac_frame_buffer: assembles 4-word sample frames into a FIFO and serves one frame per DAC request
module dac_frame_buffer #(
    parameter int dac_channels   = 4,
    parameter int fifo_depth     = 16,
    parameter int prefill_frames = 8
) (
    input  logic                          capture_clk,
    input  logic                          reset_n,
    input  logic [31:0]                   in_data,
    input  logic                          in_valid,
    input  logic                          in_first,
    output logic                          in_ready,
    input  logic                          dac_request,
    output logic [dac_channels*32-1:0]    dac_buffer,
    output logic [$clog2(fifo_depth):0]   fill_level,
    output logic                          running,
    output logic                          underrun,
    output logic                          frame_error,
    input  logic                          status_clear,
    output logic [15:0]                   underrun_count
);
    localparam int aw = $clog2(fifo_depth);
    typedef enum logic {FILLING, RUNNING} state_t;
    state_t state, state_nxt;
    logic [31:0] part [4];
    logic [1:0] idx;
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [dac_channels*32-1:0] mem [fifo_depth];
    logic accept, resync, push, pop, starve;
    // in_ready uses the pre-pop count, so a push can never overflow the FIFO
    assign in_ready = reset_n && (fill_level < (aw+1)'(fifo_depth));
    assign accept   = in_valid && in_ready;
    assign resync   = accept && in_first && idx != 2'd0;
    assign push     = accept && !resync && idx == 2'd3;
    assign pop      = dac_request && state == RUNNING && fill_level != '0;
    assign starve   = dac_request && state == RUNNING && fill_level == '0;
    always_comb begin
        state_nxt = state;
        if (state == FILLING && fill_level >= (aw+1)'(prefill_frames)) state_nxt = RUNNING;
        else if (starve) state_nxt = FILLING;
    end
    always_ff @(posedge capture_clk)
        if (push) mem[wr_ptr] <= {part[0], part[1], part[2], in_data};
    always_ff @(posedge capture_clk) begin
        if (!reset_n) begin
            state          <= FILLING;
            running        <= 1'b0;
            idx            <= 2'd0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill_level     <= '0;
            dac_buffer     <= '0;
            underrun       <= 1'b0;
            frame_error    <= 1'b0;
            underrun_count <= '0;
        end else begin
            if (accept) begin
                part[resync ? 2'd0 : idx] <= in_data;
                idx <= resync ? 2'd1 : idx + 2'd1;
            end
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
            fill_level <= fill_level + (aw+1)'(push) - (aw+1)'(pop);
            if (dac_request) dac_buffer <= pop ? mem[rd_ptr] : '0;
            frame_error <= resync | (frame_error & ~status_clear);
            underrun    <= starve | (underrun & ~status_clear);
            if (starve && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            state   <= state_nxt;
            running <= state_nxt == RUNNING;
        end
    end
endmodule

// File: tb/tb_dac_frame_buffer.sv
// tb_dac_frame_buffer: directed checks of frame assembly, prefill, underrun, resync and reset
module tb_dac_frame_buffer;
    logic capture_clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] in_data = '0;
    logic in_valid = 1'b0, in_first = 1'b0, dac_request = 1'b0, status_clear = 1'b0;
    logic in_ready, running, underrun, frame_error;
    logic [127:0] dac_buffer;
    logic [4:0] fill_level;
    logic [15:0] underrun_count;
    int n_checks = 0, n_fail = 0;

    dac_frame_buffer dut (
        .capture_clk(capture_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_ready(in_ready), .dac_request(dac_request), .dac_buffer(dac_buffer),
        .fill_level(fill_level), .running(running), .underrun(underrun), .frame_error(frame_error),
        .status_clear(status_clear), .underrun_count(underrun_count)
    );

    always #5 capture_clk = ~capture_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge capture_clk);
        #1;
    endtask

    function automatic logic [31:0] w(input int n, input int ch);
        return 32'h11000000 + 32'(ch) + 32'(16 * n);
    endfunction

    function automatic logic [127:0] fr(input int n);
        return {w(n, 0), w(n, 1), w(n, 2), w(n, 3)};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic f);
        int k = 0;
        in_data = d;
        in_first = f;
        in_valid = 1'b1;
        while (!in_ready && k < 64) begin
            tick();
            k++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int c = 0; c < 4; c++) send_word(w(n, c), c == 0);
    endtask

    task automatic request();
        dac_request = 1'b1;
        tick();
        dac_request = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_buffer", dac_buffer, 0);
        check("rst_fill", fill_level, 0);
        check("rst_running", running, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_count", underrun_count, 0);
        check("rst_ready", in_ready, 0);
        reset_n = 1'b1;
        tick();
        check("ready_after_rst", in_ready, 1);
        // prefill: running follows one cycle after the count reaches 8
        for (int n = 0; n < 8; n++) begin
            send_frame(n);
            check("prefill_ready", in_ready, 1);
        end
        check("prefill_fill", fill_level, 8);
        check("prefill_not_yet", running, 0);
        tick();
        check("prefill_running", running, 1);
        request();
        check("pop0_frame", dac_buffer, fr(0));
        check("pop0_ch0", dac_buffer[127:96], 32'h11000000);
        check("pop0_ch3", dac_buffer[31:0], 32'h11000003);
        check("pop0_fill", fill_level, 7);
        // fill to full, then a rejected word, then simultaneous push and pop
        for (int n = 8; n < 17; n++) send_frame(n);
        check("full_fill", fill_level, 16);
        check("full_ready", in_ready, 0);
        in_data = 32'hDEAD0000;
        in_first = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        check("full_reject_fill", fill_level, 16);
        request();
        check("pop1_frame", dac_buffer, fr(1));
        check("pop1_fill", fill_level, 15);
        for (int c = 0; c < 3; c++) send_word(w(17, c), c == 0);
        in_data = w(17, 3);
        in_valid = 1'b1;
        dac_request = 1'b1;
        check("pushpop_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        dac_request = 1'b0;
        check("pushpop_fill", fill_level, 15);
        check("pushpop_frame", dac_buffer, fr(2));
        for (int n = 3; n < 18; n++) begin
            request();
            check($sformatf("drain_%0d", n), dac_buffer, fr(n));
        end
        check("drained_fill", fill_level, 0);
        check("drained_running", running, 1);
        check("no_frame_error", frame_error, 0);
        request();
        check("under_buffer", dac_buffer, 0);
        check("under_flag", underrun, 1);
        check("under_count", underrun_count, 1);
        check("under_running", running, 0);
        for (int n = 20; n < 28; n++) send_frame(n);
        tick();
        check("refill_running", running, 1);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        check("clear_underrun", underrun, 0);
        check("clear_keeps_count", underrun_count, 1);
        // resync: in_first mid-frame drops ch0/ch1 of frame 30
        send_word(w(30, 0), 1'b1);
        send_word(w(30, 1), 1'b0);
        send_word(32'hAA, 1'b1);
        check("resync_error", frame_error, 1);
        send_word(32'hBB, 1'b0);
        send_word(32'hCC, 1'b0);
        send_word(32'hDD, 1'b0);
        check("resync_fill", fill_level, 9);
        for (int n = 20; n < 28; n++) begin
            request();
            check($sformatf("resync_drain_%0d", n), dac_buffer, fr(n));
        end
        request();
        check("resync_frame", dac_buffer, {32'hAA, 32'hBB, 32'hCC, 32'hDD});
        // reset mid-frame with 5 frames buffered
        for (int n = 40; n < 45; n++) send_frame(n);
        send_word(w(45, 0), 1'b1);
        send_word(w(45, 1), 1'b0);
        check("pre_rst_fill", fill_level, 5);
        reset_n = 1'b0;
        tick();
        check("mid_rst_buffer", dac_buffer, 0);
        check("mid_rst_fill", fill_level, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_frame_error", frame_error, 0);
        check("mid_rst_count", underrun_count, 0);
        check("mid_rst_ready", in_ready, 0);
        reset_n = 1'b1;
        tick();
        request();
        check("filling_req_buffer", dac_buffer, 0);
        check("filling_req_underrun", underrun, 0);
        check("filling_req_count", underrun_count, 0);
        for (int n = 50; n < 58; n++) send_frame(n);
        tick();
        check("post_rst_running", running, 1);
        request();
        check("post_rst_frame", dac_buffer, fr(50));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
